// File: rtl/wired0_defines.sv
// Shared frontend types for the fetch-address generator: prediction and correction channel structs.
package wired0_defines;

    localparam int          DEFAULT_TID_W    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;

    typedef struct packed {
        logic                     taken;
        logic [31:0]              target;
        logic [DEFAULT_TID_W-1:0] tid;
    } bpu_predict_t;

    typedef struct packed {
        logic                     redirect;
        logic [DEFAULT_TID_W-1:0] tid;
        logic [31:0]              target_pc;
        logic                     update;
        logic [31:0]              update_pc;
        logic                     update_taken;
        logic [31:0]              update_target;
    } bpu_correct_t;

    // Word address of slot i within the 8-byte fetch group containing pc.
    function automatic logic [29:0] slot_word(input logic [31:0] pc, input logic slot);
        return {pc[31:3], slot};
    endfunction

endpackage

// File: rtl/wired_btb.sv
// Direct-mapped BTB with 2-bit counters: two combinational lookups, one training write per cycle.
module wired_btb #(
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0][29:0] rd_addr_i,
    output logic [1:0]       rd_hit_o,
    output logic [1:0]       rd_pred_taken_o,
    output logic [1:0][31:0] rd_target_o,
    input  logic             wr_en_i,
    input  logic [29:0]      wr_addr_i,
    input  logic             wr_taken_i,
    input  logic [31:0]      wr_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;

    always_comb begin
        rd_hit_o        = '0;
        rd_pred_taken_o = '0;
        rd_target_o     = '0;
        for (int i = 0; i < 2; i++) begin
            rd_hit_o[i] = valid_q[rd_addr_i[i][IDX_W-1:0]] &&
                          (tag_q[rd_addr_i[i][IDX_W-1:0]] == rd_addr_i[i][29:IDX_W]);
            rd_pred_taken_o[i] = cnt_q[rd_addr_i[i][IDX_W-1:0]][1];
            rd_target_o[i]     = target_q[rd_addr_i[i][IDX_W-1:0]];
        end
    end

    assign w_idx = wr_addr_i[IDX_W-1:0];
    assign w_tag = wr_addr_i[29:IDX_W];
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    // Lookups read the pre-write contents; training becomes visible next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            if (w_hit) begin
                if (wr_taken_i) begin
                    cnt_q[w_idx]    <= (cnt_q[w_idx] == 2'd3) ? 2'd3 : cnt_q[w_idx] + 2'd1;
                    target_q[w_idx] <= wr_target_i;
                end else begin
                    cnt_q[w_idx] <= (cnt_q[w_idx] == 2'd0) ? 2'd0 : cnt_q[w_idx] - 2'd1;
                end
            end else if (wr_taken_i) begin
                valid_q[w_idx]  <= 1'b1;
                tag_q[w_idx]    <= w_tag;
                target_q[w_idx] <= wr_target_i;
                cnt_q[w_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: rtl/wired_pcgen.sv
// Fetch-address generator: offers one two-slot fetch group per cycle with BTB-based prediction.
module wired_pcgen
    import wired0_defines::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BTB_ENTRIES = 16,
    parameter int          TID_W       = DEFAULT_TID_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  bpu_correct_t       p_correct_i,
    input  logic               p_ready_i,
    output logic               p_valid_o,
    output logic [31:0]        p_pc_o,
    output logic [1:0]         p_mask_o,
    output bpu_predict_t [1:0] p_predict_o
);

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [TID_W-1:0] tid_q;
    logic             valid_q;

    logic [1:0][29:0] rd_addr;
    logic [1:0]       hit;
    logic [1:0]       pred_taken;
    logic [1:0][31:0] hit_target;

    logic [1:0]         base_mask;
    logic [1:0]         taken;
    logic [1:0]         mask;
    logic [31:0]        seq_npc;
    bpu_predict_t [1:0] pred;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{p_correct_i.target_pc[1:0], p_correct_i.update_pc[1:0]};

    assign rd_addr[0] = slot_word(pc_q, 1'b0);
    assign rd_addr[1] = slot_word(pc_q, 1'b1);

    wired_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_addr_i       (rd_addr),
        .rd_hit_o        (hit),
        .rd_pred_taken_o (pred_taken),
        .rd_target_o     (hit_target),
        .wr_en_i         (p_correct_i.update),
        .wr_addr_i       (p_correct_i.update_pc[31:2]),
        .wr_taken_i      (p_correct_i.update_taken),
        .wr_target_i     (p_correct_i.update_target)
    );

    // A taken slot 0 kills slot 1; a group entered at pc[2]=1 never offers slot 0.
    always_comb begin
        base_mask = pc_q[2] ? 2'b10 : 2'b11;
        seq_npc   = {pc_q[31:3] + 29'd1, 3'b000};
        taken     = hit & pred_taken & base_mask;
        mask      = base_mask;
        pc_d      = seq_npc;
        if (taken[0]) begin
            mask = base_mask & 2'b01;
            pc_d = hit_target[0];
        end else if (taken[1]) begin
            pc_d = hit_target[1];
        end
    end

    always_comb begin
        pred = '0;
        for (int i = 0; i < 2; i++) begin
            pred[i].taken  = taken[i];
            pred[i].target = hit[i] ? hit_target[i] : seq_npc;
            pred[i].tid    = tid_q;
        end
    end

    assign p_valid_o   = rst_n & valid_q & ~p_correct_i.redirect;
    assign p_pc_o      = pc_q;
    assign p_mask_o    = rst_n ? mask : 2'b00;
    assign p_predict_o = rst_n ? pred : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            tid_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (p_correct_i.redirect) begin
                pc_q  <= {p_correct_i.target_pc[31:2], 2'b00};
                tid_q <= p_correct_i.tid;
            end else if (p_valid_o && p_ready_i) begin
                pc_q <= pc_d;
            end
        end
    end

endmodule

// File: tb/tb_wired_pcgen.sv
// Bench for wired_pcgen: directed scenarios plus random traffic against a behavioural model.
module tb_wired_pcgen;
    import wired0_defines::*;

    localparam int N = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    bpu_correct_t       corr;
    logic               ready;
    logic               valid;
    logic [31:0]        pc;
    logic [1:0]         mask;
    bpu_predict_t [1:0] pred;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wired_pcgen #(.RESET_PC(32'h1c000000), .BTB_ENTRIES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_correct_i (corr),
        .p_ready_i   (ready),
        .p_valid_o   (valid),
        .p_pc_o      (pc),
        .p_mask_o    (mask),
        .p_predict_o (pred)
    );

    // Model state: fetch PC, tag, handshake-valid and a BTB kept as plain arrays.
    logic [31:0] m_pc;
    logic [3:0]  m_tid;
    bit          m_valid;
    bit          mv   [N];
    logic [31:0] mtag [N];
    logic [31:0] mtgt [N];
    int          mcnt [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_pc    = 32'h1c000000;
        m_tid   = 4'd0;
        m_valid = 1'b0;
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
    endfunction

    task automatic idle_in();
        corr  = '0;
        ready = 1'b0;
        #1;
    endtask

    task automatic step(input bit rd, input logic [3:0] rtid, input logic [31:0] rtp,
                        input bit up, input logic [31:0] upc, input bit utk,
                        input logic [31:0] utg, input bit rdy);
        logic [31:0] seq, npc, a;
        logic [1:0]  base, ex_mask;
        bit          ex_tk [2];
        logic [31:0] ex_tg [2];
        bit          ev, hit;
        int          idx;
        corr.redirect      = rd;
        corr.tid           = rtid;
        corr.target_pc     = rtp;
        corr.update        = up;
        corr.update_pc     = upc;
        corr.update_taken  = utk;
        corr.update_target = utg;
        ready              = rdy;
        #1;
        ev  = 1'b0;
        npc = '0;
        if (!rst_n) begin
            chk("rst_valid", valid, 0);
            chk("rst_mask", mask, 0);
            chk("rst_pred0", pred[0], 0);
            chk("rst_pred1", pred[1], 0);
        end else begin
            base = m_pc[2] ? 2'b10 : 2'b11;
            seq  = (m_pc & ~32'h7) + 32'd8;
            for (int i = 0; i < 2; i++) begin
                a         = (m_pc & ~32'h7) + 32'(i * 4);
                idx       = int'((a >> 2) % N);
                hit       = mv[idx] && (mtag[idx] == (a >> 6));
                ex_tk[i]  = hit && (mcnt[idx] >= 2) && base[i];
                ex_tg[i]  = hit ? mtgt[idx] : seq;
            end
            if (ex_tk[0]) begin
                ex_mask = base & 2'b01;
                npc     = ex_tg[0];
            end else if (ex_tk[1]) begin
                ex_mask = base;
                npc     = ex_tg[1];
            end else begin
                ex_mask = base;
                npc     = seq;
            end
            ev = m_valid && !rd;
            chk("valid", valid, ev);
            chk("pc", pc, m_pc);
            chk("mask", mask, ex_mask);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("taken%0d", i), pred[i].taken, ex_tk[i]);
                chk($sformatf("target%0d", i), pred[i].target, ex_tg[i]);
                chk($sformatf("tid%0d", i), pred[i].tid, m_tid);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            if (up) begin
                idx = int'((upc >> 2) % N);
                hit = mv[idx] && (mtag[idx] == (upc >> 6));
                if (hit && utk) begin
                    mcnt[idx] = (mcnt[idx] < 3) ? mcnt[idx] + 1 : 3;
                    mtgt[idx] = utg;
                end else if (hit) begin
                    mcnt[idx] = (mcnt[idx] > 0) ? mcnt[idx] - 1 : 0;
                end else if (utk) begin
                    mv[idx]   = 1'b1;
                    mtag[idx] = upc >> 6;
                    mtgt[idx] = utg;
                    mcnt[idx] = 2;
                end
            end
            if (rd) begin
                m_pc  = rtp & ~32'h3;
                m_tid = rtid;
            end else if (ev && rdy) begin
                m_pc = npc;
            end
            m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic go(input bit rdy);
        step(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic redir(input logic [3:0] t, input logic [31:0] p, input bit rdy);
        step(1, t, p, 0, 0, 0, 0, rdy);
    endtask

    task automatic train(input logic [31:0] upc, input bit tk, input logic [31:0] tg);
        step(0, 0, 0, 1, upc, tk, tg, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        corr  = '0;
        ready = 1'b0;
        m_reset();
        @(negedge clk);
        repeat (3) go(1);
        rst_n = 1'b1;
        go(1);

        idle_in();
        chk("first_valid", valid, 1);
        chk("first_pc", pc, 32'h1c000000);
        chk("first_mask", mask, 2'b11);
        repeat (3) go(1);

        redir(4'd5, 32'h1c000104, 1);
        idle_in();
        chk("redir_pc", pc, 32'h1c000104);
        chk("redir_mask", mask, 2'b10);
        chk("redir_tid", pred[1].tid, 4'd5);
        go(1);
        idle_in();
        chk("redir_next_pc", pc, 32'h1c000108);
        chk("redir_next_mask", mask, 2'b11);

        train(32'h1c000020, 1, 32'h1c000400);
        redir(4'd1, 32'h1c000020, 0);
        idle_in();
        chk("s0_mask", mask, 2'b01);
        chk("s0_taken", pred[0].taken, 1);
        chk("s0_target", pred[0].target, 32'h1c000400);
        go(1);
        idle_in();
        chk("s0_npc", pc, 32'h1c000400);

        train(32'h1c000044, 1, 32'h1c000400);
        redir(4'd2, 32'h1c000040, 0);
        idle_in();
        chk("s1_mask", mask, 2'b11);
        chk("s1_taken", pred[1].taken, 1);
        chk("s1_slot0", pred[0].taken, 0);
        go(1);
        idle_in();
        chk("s1_npc", pc, 32'h1c000400);

        train(32'h1c000080, 1, 32'h1c000200);
        train(32'h1c000080, 0, 32'h0);
        train(32'h1c000080, 0, 32'h0);
        redir(4'd3, 32'h1c000080, 0);
        idle_in();
        chk("cnt0_taken", pred[0].taken, 0);
        chk("cnt0_hit_target", pred[0].target, 32'h1c000200);
        train(32'h1c000080, 1, 32'h1c000200);
        idle_in();
        chk("cnt1_taken", pred[0].taken, 0);
        train(32'h1c000080, 1, 32'h1c000200);
        idle_in();
        chk("cnt2_taken", pred[0].taken, 1);

        repeat (3) go(0);
        redir(4'd4, 32'h1c000300, 0);
        idle_in();
        chk("stall_redir_pc", pc, 32'h1c000300);
        redir(4'd6, 32'hfffffff8, 0);
        go(1);
        idle_in();
        chk("wrap_pc", pc, 32'h00000000);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] rtp, upc, utg;
            rtp = 32'h1c000000 + 32'($urandom_range(0, 127) * 4);
            upc = 32'h1c000000 + 32'($urandom_range(0, 127) * 4);
            utg = 32'h1c000000 + 32'($urandom_range(0, 127) * 4);
            if (n == 700) rst_n = 1'b0;
            if (n == 702) rst_n = 1'b1;
            step(($urandom % 16) == 0, 4'($urandom), rtp,
                 ($urandom % 4) == 0, upc, ($urandom % 3) != 0, utg,
                 ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wired_pcgen.md
Name: wired_pcgen

Overview:
- Fetch-address generator at the head of the frontend. Feeds the W->F skid buffer and the icache.
- Each cycle it offers one 8-byte-aligned fetch group of two instruction slots, with a per-slot valid mask and per-slot branch prediction.
- Prediction comes from a small internal direct-mapped BTB with 2-bit counters.
- Redirects and BTB training both arrive on the backend's bpu_correct_t channel.

Parameters:
- RESET_PC, 32'h1c000000, fetch address after reset.
- BTB_ENTRIES, 16, BTB depth. Power of two, ≥4.
- TID_W, 4, width of the redirect/transaction tag stamped on every prediction.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- p_correct_i  in  bpu_correct_t  redirect plus BTB update from backend
- p_ready_i  in  1  downstream accepts the current group
- p_valid_o  out  1  fetch group valid
- p_pc_o  out  32  PC of the group's first valid slot
- p_mask_o  out  2  slot valid mask; bit i = instruction at {pc[31:3], i, 2'b00}
- p_predict_o  out  bpu_predict_t[1:0]  per-slot prediction {taken, target[31:0], tid[TID_W-1:0]}

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk.
  - pc_q=RESET_PC, tid_q=0, valid_q=0, all BTB valid bits=0.
  - During reset: p_valid_o=0, p_mask_o=0, p_predict_o=0.
  - First cycle after reset release: valid_q=1.
- Output: p_valid_o = valid_q & !p_correct_i.redirect. p_pc_o = pc_q.
- Base mask: 2'b11 if pc_q[2]==0, else 2'b10.
- Lookup: slot i address a_i = {pc_q[31:3], i, 2'b00}. Index = a_i[IDX_W+1:2] with IDX_W = log2(BTB_ENTRIES). Tag = a_i[31:IDX_W+2].
- hit_i = entry.valid & tag match. taken_i = hit_i & cnt[1] & base_mask[i].
- Next PC and final mask:
  - taken_0: p_mask_o = base & 2'b01, npc = target_0.
  - else taken_1: p_mask_o = base, npc = target_1.
  - else: npc = {pc_q[31:3]+1, 3'b000}. Wraps 32'hFFFFFFF8 -> 0.
- p_predict_o[i]:
  - taken = taken_i (0 for masked slots).
  - target = entry target when hit, else sequential npc.
  - tid = tid_q.
- Advance: on p_valid_o & p_ready_i, pc_q <= npc. Otherwise pc_q holds and all outputs are stable (AXI-style hold rule).
- Redirect (p_correct_i.redirect=1):
  - pc_q <= {target_pc[31:2], 2'b00} (low two bits ignored).
  - tid_q <= p_correct_i.tid.
  - Overrides advance in the same cycle.
  - p_valid_o is low in the redirect cycle. The group at the new PC is offered the next cycle, stamped with the new tid.
- BTB update (p_correct_i.update=1, independent of redirect), at index/tag of update_pc:
  - hit & taken: cnt saturating ++ (max 3), target <= update_target.
  - hit & !taken: cnt saturating -- (min 0). Entry stays valid.
  - miss & taken: allocate/overwrite. valid=1, tag, target, cnt=2'b10.
  - miss & !taken: no change.
- Update vs lookup in the same cycle to the same index: the lookup sees the pre-update entry. The write is visible the next cycle.
- Reset mid-operation: all state returns to reset values; pending handshake is dropped.

Decomposition:
- wired0_defines package holds:
  - bpu_predict_t {taken, target, tid}
  - bpu_correct_t {redirect, tid, target_pc, update, update_pc, update_taken, update_target}
  - TID_W default
  - RESET_PC constant
- Sub-module wired_btb: storage, 2-comb read ports, 1 write port with counter update logic.
- wired_pcgen keeps pc/tid/valid state and next-PC selection.

Test Plan:
- Reset then hold p_ready_i=1, empty BTB -> first valid group pc=1c000000 mask=11. Following groups 1c000008, 1c000010, one per cycle. All taken=0, tid=0.
- Redirect target_pc=1c000104 tid=5 -> p_valid_o=0 that cycle. Next group pc=1c000104 mask=10, predict tid=5. Then 1c000108 mask=11.
- Update update_pc=1c000020 taken target=1c000400, then fetch 1c000020 -> mask=01, predict[0].taken=1 target=1c000400. Next pc=1c000400.
- Slot-1 branch at 1c000044, trained taken -> group 1c000040 mask=11, predict[1].taken=1. Next group 1c000400.
- Counter training: one taken update (cnt=2), two not-taken updates -> cnt=0, not predicted. Entry stays valid. One taken -> cnt=1, still not taken. Another -> cnt=2, predicted.
- p_ready_i=0 for 3 cycles -> pc/mask/predict stable. Redirect during stall -> new PC next cycle. Redirect to FFFFFFF8 -> next group wraps to 00000000.
